// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer with miss-buffered branch redirect
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [15:0] br_target,
    input  logic        hazard_stall,
    input  logic        imem_busy,
    input  logic        hlt_if,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        halted,
    output logic        redirect_pending,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {RUN, MISS, HALT} state_t;

    state_t      state, state_n;
    logic [15:0] pc_n;
    logic [15:0] redir, redir_n;
    logic        pending, pending_n;
    logic        eb, eff_br;
    logic [15:0] eff_tgt;

    assign pc_inc           = pc + PC_STEP;
    assign halted           = (state == HALT);
    assign redirect_pending = pending;
    assign eb               = branch & ~hazard_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pc      <= RESET_PC;
            redir   <= 16'h0000;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            redir   <= redir_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        redir_n    = redir;
        pending_n  = pending;
        ifid_wen   = 1'b0;
        ifid_flush = 1'b0;
        // A buffered redirect outranks any branch seen on the miss-completion cycle.
        eff_br     = eb | ((state == MISS) & pending);
        eff_tgt    = ((state == MISS) && pending) ? redir : br_target;
        case (state)
            RUN, MISS: begin
                if ((state == MISS) && imem_busy) begin
                    ifid_flush = ~hazard_stall;
                    if (eb && !pending) begin
                        redir_n   = br_target;
                        pending_n = 1'b1;
                    end
                end else if (eff_br && imem_busy) begin
                    redir_n    = eff_tgt;
                    pending_n  = 1'b1;
                    state_n    = MISS;
                    ifid_flush = 1'b1;
                end else if (eff_br) begin
                    pc_n       = eff_tgt;
                    pending_n  = 1'b0;
                    state_n    = RUN;
                    ifid_flush = 1'b1;
                end else if (hazard_stall) begin
                    state_n = RUN;
                end else if (imem_busy) begin
                    state_n    = MISS;
                    ifid_flush = 1'b1;
                end else if (hlt_if) begin
                    ifid_wen = 1'b1;
                    state_n  = HALT;
                end else begin
                    pc_n     = pc_inc;
                    ifid_wen = 1'b1;
                    state_n  = RUN;
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (((state == MISS) || ((state == RUN) && hazard_stall)) && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (ifid_flush && (state != HALT) && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule
